// File: rtl/phys_reg_free_list_if.sv
// Rename/commit handshake bundle for the physical register free list.
// The master drives requests and releases; the slave (the free list) returns tags and status.
interface phys_reg_free_list_if #(
  parameter int PHY_WIDTH = 6,
  parameter int PTR_WIDTH = 6
);
  logic                 alloc_req;
  logic                 alloc_valid;
  logic [PHY_WIDTH-1:0] alloc_preg;
  logic                 commit_valid;
  logic [PHY_WIDTH-1:0] commit_old_preg;
  logic                 flush;
  logic [PTR_WIDTH-1:0] free_count;
  logic                 empty;
  logic                 err;

  modport master (
    output alloc_req, commit_valid, commit_old_preg, flush,
    input  alloc_valid, alloc_preg, free_count, empty, err
  );

  modport slave (
    input  alloc_req, commit_valid, commit_old_preg, flush,
    output alloc_valid, alloc_preg, free_count, empty, err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: one allocation per cycle to rename,
// one release per cycle from commit, and single-cycle flush back to the committed head.
module phys_reg_free_list #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int FREE_REG  = PHY_REGS - ARCH_REGS,
  parameter int PHY_WIDTH = $clog2(PHY_REGS),
  parameter int PTR_WIDTH = $clog2(FREE_REG) + 1
) (
  input logic                clk,
  input logic                rst,
  phys_reg_free_list_if.slave fl
);
  localparam int IDX_WIDTH = $clog2(FREE_REG);

  logic [PHY_WIDTH-1:0] entries [FREE_REG];
  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] commit_head;
  logic [PTR_WIDTH-1:0] tail;
  logic [PTR_WIDTH-1:0] head_next;
  logic [PTR_WIDTH-1:0] count;
  logic                 err_q;
  logic                 full;
  logic                 alloc_fire;
  logic                 push;

  // Full and empty differ only in the wrap bit, so the modular difference covers both.
  always_comb begin
    count      = tail - head;
    full       = (count == PTR_WIDTH'(FREE_REG));
    alloc_fire = fl.alloc_req && (count != '0) && !fl.flush;
    push       = fl.commit_valid && !full;
    if (fl.flush) begin
      head_next = commit_head + (fl.commit_valid ? PTR_WIDTH'(1) : '0);
    end else begin
      head_next = head + (alloc_fire ? PTR_WIDTH'(1) : '0);
    end
  end

  assign fl.free_count  = count;
  assign fl.empty       = (count == '0);
  assign fl.alloc_valid = (count != '0) && !fl.flush;
  assign fl.alloc_preg  = entries[head[IDX_WIDTH-1:0]];
  assign fl.err         = err_q;

  // A release with the list full is dropped, but commit_head still tracks the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FREE_REG; i++) begin
        entries[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
      head        <= '0;
      commit_head <= '0;
      tail        <= PTR_WIDTH'(FREE_REG);
      err_q       <= 1'b0;
    end else begin
      head <= head_next;
      if (fl.commit_valid) begin
        commit_head <= commit_head + PTR_WIDTH'(1);
      end
      if (push) begin
        entries[tail[IDX_WIDTH-1:0]] <= fl.commit_old_preg;
        tail                         <= tail + PTR_WIDTH'(1);
      end
      if (fl.commit_valid && full) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: a vector table for reset, drain and release-into-empty,
// then hand-written sequences for flush recovery, steady state across wrap, overflow and async reset.
module tb_phys_reg_free_list;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  phys_reg_free_list_if #(.PHY_WIDTH(6), .PTR_WIDTH(6)) fl ();

  phys_reg_free_list #(.PHY_REGS(64), .ARCH_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl.slave)
  );

  typedef struct {
    logic       alloc_req;
    logic       commit_valid;
    logic [5:0] old_preg;
    logic       flush;
    logic       exp_valid;
    logic [5:0] exp_preg;
    logic [5:0] exp_count;
    logic       exp_empty;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ar, input logic cv, input logic [5:0] op, input logic fs,
                              input logic ev, input logic [5:0] ep, input logic [5:0] ec,
                              input logic ee, input logic er);
    vec_t v;
    v.alloc_req = ar; v.commit_valid = cv; v.old_preg = op; v.flush = fs;
    v.exp_valid = ev; v.exp_preg = ep; v.exp_count = ec; v.exp_empty = ee; v.exp_err = er;
    return v;
  endfunction

  task automatic applyStimulus(input logic ar, input logic cv, input logic [5:0] op, input logic fs);
    fl.alloc_req       = ar;
    fl.commit_valid    = cv;
    fl.commit_old_preg = op;
    fl.flush           = fs;
    #1;
  endtask

  task automatic checkField(input string name, input string field, input logic [5:0] act,
                            input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // alloc_preg is only meaningful while a tag is offered, so it is compared only then.
  task automatic checkOutput(input string name, input logic ev, input logic [5:0] ep,
                             input logic [5:0] ec, input logic ee, input logic er);
    checkField(name, "alloc_valid", {5'd0, fl.alloc_valid}, {5'd0, ev});
    if (ev) checkField(name, "alloc_preg", fl.alloc_preg, ep);
    checkField(name, "free_count", fl.free_count, ec);
    checkField(name, "empty", {5'd0, fl.empty}, {5'd0, ee});
    checkField(name, "err", {5'd0, fl.err}, {5'd0, er});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    fl.alloc_req = 1'b0; fl.commit_valid = 1'b0; fl.commit_old_preg = '0; fl.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, drain 32..63, 33rd request, release into empty without bypass.
    vecs.push_back(mk(0, 0, 0, 0, 1, 32, 32, 0, 0));
    for (int i = 0; i < 32; i++) vecs.push_back(mk(1, 0, 0, 0, 1, 6'(32 + i), 6'(32 - i), 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].alloc_req, vecs[i].commit_valid, vecs[i].old_preg, vecs[i].flush);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_preg,
                  vecs[i].exp_count, vecs[i].exp_empty, vecs[i].exp_err);
      tick();
    end

    // Asynchronous reset mid-cycle must restore the overwritten entry and drop the pending request.
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", 1, 32, 32, 0, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("post_rst", 1, 32, 32, 0, 0);

    // Flush recovery: allocate 32..35, commit once releasing 7, flush with a request pending.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
      checkOutput($sformatf("fl_alloc%0d", i), 1, 6'(32 + i), 6'(32 - i), 0, 0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 6'd7, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("fl_commit", 1, 36, 29, 0, 0);
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b1);
    checkOutput("fl_during", 0, 0, 29, 0, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("fl_after", 1, 33, 32, 0, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
      checkOutput($sformatf("fl_drain%0d", i), 1, (i < 31) ? 6'(33 + i) : 6'd7, 6'(32 - i), 0, 0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("fl_empty", 0, 0, 0, 1, 0);

    // A commit in the flush cycle counts as committed: head lands one past the old commit head.
    applyStimulus(1'b1, 1'b1, 6'd9, 1'b1);
    checkOutput("flc_during", 0, 0, 0, 1, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("flc_after", 1, 34, 32, 0, 0);

    // Steady state at free_count 10 across the pointer wrap.
    doReset();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("ss_start", 1, 54, 10, 0, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1, 6'(10 + k), 1'b0);
      checkOutput($sformatf("ss%0d", k), 1, (k < 10) ? 6'(54 + k) : 6'(k), 10, 0, 0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("ss_end", 1, 20, 10, 0, 0);

    // Overflow: release into a full list is dropped and latches err until reset.
    doReset();
    applyStimulus(1'b0, 1'b1, 6'd3, 1'b0);
    checkOutput("ovf_before", 1, 32, 32, 0, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("ovf_after", 1, 32, 32, 0, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
      checkOutput($sformatf("ovf_alloc%0d", i), 1, 6'(32 + i), 6'(32 - i), 0, 1);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 6'd4, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("ovf_rst", 1, 32, 32, 0, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("ovf_post_rst", 1, 32, 32, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular free list of physical register tags for the rename stage of the out-of-order core. It hands one free physical register per cycle to rename and accepts one released register per cycle from commit (the previous mapping of the committing destination). It keeps a committed head pointer so that a pipeline flush restores every speculatively allocated tag in one cycle. Capacity is PHY_REGS − ARCH_REGS entries.

## Interface
- PHY_REGS, 64, number of physical registers
- ARCH_REGS, 32, number of architectural registers; tags 0..ARCH_REGS−1 are mapped at reset
- FREE_REG, PHY_REGS−ARCH_REGS (32), list depth
- PHY_WIDTH, $clog2(PHY_REGS) (6), tag width
- PTR_WIDTH, $clog2(FREE_REG)+1 (6), pointer width including wrap bit

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  rename requests one tag this cycle
- alloc_valid  out  1  a tag is available and the request is granted if alloc_req=1
- alloc_preg  out  PHY_WIDTH  tag at speculative head
- commit_valid  in  1  a destination-writing instruction commits this cycle
- commit_old_preg  in  PHY_WIDTH  tag released by that commit
- flush  in  1  squash all uncommitted allocations
- free_count  out  PTR_WIDTH  entries between head and tail, 0..FREE_REG
- empty  out  1  free_count == 0
- err  out  1  sticky overflow flag (release with list full)

## Operation
- Storage: FREE_REG × PHY_WIDTH array; pointers head (speculative), commit_head, tail, each PTR_WIDTH with wrap bit; index = low $clog2(FREE_REG) bits.
- Reset: entry[i] = ARCH_REGS+i; head=0, commit_head=0, tail=FREE_REG (wrap bit set, index 0); err=0.
- free_count = tail − head (PTR_WIDTH modular); empty = (free_count==0).
- alloc_valid = !empty && !flush. alloc_preg = entry[head index] (combinational from state).
- Allocate: alloc_req && alloc_valid → head+1 at edge.
- Release: commit_valid → if free_count==FREE_REG: push dropped, err set; else entry[tail index] = commit_old_preg, tail+1. commit_head+1 on every commit_valid regardless.
- Flush: head ← commit_head + commit_valid (same-cycle commit included); alloc ignored; tail push still performed.
- Simultaneous alloc + release (non-empty): head+1 and tail+1, free_count unchanged.
- Release while empty: no same-cycle bypass; alloc_valid stays 0 that cycle, tag allocatable next cycle.
- Invariant (verification assertion): commit_head never passes head; commits never exceed allocations.

## Timing
- Reset values: alloc_valid=1, alloc_preg=ARCH_REGS (32), free_count=32, empty=0, err=0.
- Allocation latency 0: tag visible same cycle as request; head advance visible next cycle.
- Released tag visible in free_count the cycle after commit_valid.
- Flush takes effect in one cycle; alloc_valid=0 during the flush cycle, valid again next cycle if non-empty.
- rst asserted mid-operation: immediate (asynchronous) return to reset state incl. array re-initialisation; pending alloc/commit in that cycle discarded.
- Pointer wrap: index wraps at FREE_REG, wrap bit toggles; full vs empty distinguished by wrap bit only.

## Test plan
- Reset: after rst release, alloc_preg=32, free_count=32, alloc_valid=1, empty=0, err=0.
- Drain: 32 consecutive alloc_req → tags 32..63 in order; then empty=1, alloc_valid=0; 33rd request leaves head and free_count=0 unchanged.
- Release into empty: with list empty, commit_valid with old_preg=5 and alloc_req same cycle → no grant; next cycle alloc_valid=1, alloc_preg=5, free_count=1.
- Flush recovery: from reset, allocate 4 (32..35), commit once with old_preg=7, then flush → free_count=32, alloc_preg=33; draining yields 33..63 then 7.
- Steady state: at free_count=10, alloc_req and commit_valid together for 20 cycles → free_count stays 10, tags returned in FIFO order across pointer wrap.
- Overflow + reset: commit_valid at free_count=32 → err=1, free_count stays 32, contents unchanged; assert rst mid-stream → all outputs return to reset values, err=0.
